// File: rtl/rv32i_types.sv
// Shared types and sizing constants for the cache side of the memory system.
package rv32i_types;

    localparam int CACHELINE_W = 256;
    localparam int BMEM_BEAT_W = 64;
    localparam int BMEM_BURSTS = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } cla_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: turns one 256-bit line request from the arbiter into a
// single bmem read command plus four returned beats, or into four bmem write
// beats. Only one request is in flight at a time.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int BEAT_W = BMEM_BEAT_W,
    parameter int BURSTS = BMEM_BURSTS
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [31:0]                dfp_addr,
    input  logic                       dfp_read,
    input  logic                       dfp_write,
    input  logic [BEAT_W*BURSTS-1:0]   dfp_wdata,
    output logic [BEAT_W*BURSTS-1:0]   dfp_rdata,
    output logic                       dfp_resp,

    output logic [31:0]                bmem_addr,
    output logic                       bmem_read,
    output logic                       bmem_write,
    output logic [BEAT_W-1:0]          bmem_wdata,
    input  logic                       bmem_ready,
    input  logic [31:0]                bmem_raddr,
    input  logic [BEAT_W-1:0]          bmem_rdata,
    input  logic                       bmem_rvalid
);

    localparam int LINE_W   = BEAT_W * BURSTS;
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int CNT_W    = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    // Clears the byte-offset bits so every bmem address is line aligned.
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);

    cla_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;

    // A returning beat only belongs to us when its tag matches the line we asked for.
    logic beatHit;
    assign beatHit = bmem_rvalid && (bmem_raddr == addr_q);

    // State, beat counter, latched address and both line buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Next-state logic; the counter only wraps to zero on the last beat, which is also the state exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;

        case (state_q)
            IDLE: begin
                if (dfp_read) begin
                    addr_d  = dfp_addr & LINE_MASK;
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else if (dfp_write) begin
                    addr_d  = dfp_addr & LINE_MASK;
                    wline_d = dfp_wdata;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end
            end

            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (beatHit) begin
                    for (int k = 0; k < BURSTS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            rline_d[k*BEAT_W +: BEAT_W] = bmem_rdata;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end

            WR_BURST: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dfp_resp   = (state_q == RESP);
    assign dfp_rdata  = rline_q;
    assign bmem_read  = (state_q == RD_REQ);
    assign bmem_write = (state_q == WR_BURST);
    assign bmem_addr  = addr_q;

    // Present the write beat selected by the counter; it holds still while bmem stalls.
    always_comb begin
        bmem_wdata = '0;
        for (int k = 0; k < BURSTS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                bmem_wdata = wline_q[k*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios followed by
// randomized reads and writes against a line-level model of the transfers.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad   = 0;

    // Beats the memory will return for the next read, and the line last read.
    logic [63:0]  beatTab [4];
    logic [255:0] lastLine;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [63:0] randBeat();
        return {$urandom, $urandom};
    endfunction

    task automatic fillRandomBeats();
        for (int i = 0; i < 4; i++) begin
            beatTab[i] = randBeat();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] wdata);
        dfp_read  = rd;
        dfp_write = wr;
        dfp_addr  = addr;
        dfp_wdata = wdata;
    endtask

    // Outputs expected in the idle cycle that follows every completed request.
    task automatic checkIdle(input string tag);
        checkOutput({tag, "_idle_resp"}, dfp_resp, 1'b0);
        checkOutput({tag, "_idle_read"}, bmem_read, 1'b0);
        checkOutput({tag, "_idle_write"}, bmem_write, 1'b0);
    endtask

    // Line read: must be called in an idle cycle; returns in the following idle cycle.
    task automatic applyRead(input logic [31:0] addr, input int maxStall, input bit foreign, input bit alsoWrite);
        logic [31:0]  lineAddr;
        logic [255:0] expLine;
        int           stall;
        int           beatIdx;
        int           cyc;
        int           r;
        bit           accepted;
        bit           done;

        lineAddr = {addr[31:5], 5'b0};
        expLine  = {beatTab[3], beatTab[2], beatTab[1], beatTab[0]};
        applyStimulus(1'b1, alsoWrite, addr, randLine());
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        tick();
        dfp_addr  = $urandom;
        dfp_wdata = randLine();
        stall    = int'($urandom_range(maxStall, 0));
        beatIdx  = 0;
        accepted = 1'b0;
        done     = 1'b0;
        cyc      = 1;
        checkOutput("rd_cmd_first", bmem_read, 1'b1);

        while (!done && cyc < 400) begin
            if (alsoWrite) begin
                checkOutput("rd_no_write", bmem_write, 1'b0);
            end
            if (!accepted) begin
                checkOutput("rd_cmd_hold", bmem_read, 1'b1);
                checkOutput("rd_addr", bmem_addr, lineAddr);
                bmem_rvalid = 1'($urandom_range(1, 0));
                bmem_raddr  = lineAddr;
                bmem_rdata  = randBeat();
                if (stall > 0) begin
                    bmem_ready = 1'b0;
                    stall--;
                end else begin
                    bmem_ready = 1'b1;
                    accepted   = 1'b1;
                end
            end else if (beatIdx == 4) begin
                checkOutput("rd_resp", dfp_resp, 1'b1);
                checkOutput("rd_data", dfp_rdata, expLine);
                lastLine = expLine;
                done     = 1'b1;
                applyStimulus(1'b0, 1'b0, $urandom, randLine());
                bmem_rvalid = 1'b0;
                bmem_ready  = 1'b0;
            end else begin
                checkOutput("rd_cmd_drop", bmem_read, 1'b0);
                checkOutput("rd_early_resp", dfp_resp, 1'b0);
                bmem_ready = 1'($urandom_range(1, 0));
                r = int'($urandom_range(3, 0));
                if (foreign && r == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = lineAddr ^ 32'h0000_2000;
                    bmem_rdata  = randBeat();
                end else if (r == 1) begin
                    bmem_rvalid = 1'b0;
                    bmem_raddr  = lineAddr;
                    bmem_rdata  = randBeat();
                end else begin
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = lineAddr;
                    bmem_rdata  = beatTab[beatIdx];
                    beatIdx++;
                end
            end
            tick();
            cyc++;
        end
        checkOutput("rd_completed", done, 1'b1);
        checkIdle("rd");
    endtask

    // Line write with ready dropped on the cycles flagged in stallMask.
    task automatic applyWrite(input logic [31:0] addr, input logic [255:0] line, input logic [15:0] stallMask);
        logic [31:0] lineAddr;
        int          cyc;
        int          accepted;
        int          stalls;
        bit          done;

        lineAddr = {addr[31:5], 5'b0};
        applyStimulus(1'b0, 1'b1, addr, line);
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        tick();
        dfp_addr  = $urandom;
        dfp_wdata = randLine();
        cyc      = 1;
        accepted = 0;
        stalls   = 0;
        done     = 1'b0;

        while (!done && cyc < 400) begin
            bmem_rvalid = 1'($urandom_range(1, 0));
            bmem_raddr  = lineAddr;
            bmem_rdata  = randBeat();
            if (accepted == 4) begin
                checkOutput("wr_resp", dfp_resp, 1'b1);
                checkOutput("wr_resp_cycle", cyc, 5 + stalls);
                checkOutput("wr_rdata_kept", dfp_rdata, lastLine);
                done = 1'b1;
                applyStimulus(1'b0, 1'b0, $urandom, randLine());
                bmem_ready  = 1'b0;
                bmem_rvalid = 1'b0;
            end else begin
                checkOutput("wr_early_resp", dfp_resp, 1'b0);
                checkOutput("wr_valid", bmem_write, 1'b1);
                checkOutput("wr_no_read", bmem_read, 1'b0);
                checkOutput("wr_addr", bmem_addr, lineAddr);
                checkOutput("wr_data", bmem_wdata, line[accepted*64 +: 64]);
                if (cyc < 16 && stallMask[cyc]) begin
                    bmem_ready = 1'b0;
                    stalls++;
                end else begin
                    bmem_ready = 1'b1;
                    accepted++;
                end
            end
            tick();
            cyc++;
        end
        checkOutput("wr_completed", done, 1'b1);
        checkIdle("wr");
    endtask

    // Everything visible must be zero while reset is held.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_resp"}, dfp_resp, 1'b0);
        checkOutput({tag, "_rdata"}, dfp_rdata, 256'd0);
        checkOutput({tag, "_bread"}, bmem_read, 1'b0);
        checkOutput({tag, "_bwrite"}, bmem_write, 1'b0);
        checkOutput({tag, "_baddr"}, bmem_addr, 32'd0);
        checkOutput({tag, "_bwdata"}, bmem_wdata, 64'd0);
    endtask

    initial begin
        logic [255:0] line;
        int           kind;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        bmem_ready  = 1'b0;
        bmem_raddr  = 32'd0;
        bmem_rdata  = 64'd0;
        bmem_rvalid = 1'b0;
        lastLine    = 256'd0;
        #1;
        checkResetOutputs("por");
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkIdle("post_reset");

        $display("[TB] read of 0x1040 with fixed beat pattern");
        beatTab[0] = 64'h1111_1111_1111_1111;
        beatTab[1] = 64'h2222_2222_2222_2222;
        beatTab[2] = 64'h3333_3333_3333_3333;
        beatTab[3] = 64'h4444_4444_4444_4444;
        applyRead(32'h0000_1040, 0, 1'b0, 1'b0);

        $display("[TB] write to 0x2000 with a stall on cycle 2");
        line = {64'hDDDD_DDDD_0000_0004, 64'hCCCC_CCCC_0000_0003,
                64'hBBBB_BBBB_0000_0002, 64'hAAAA_AAAA_0000_0001};
        applyWrite(32'h0000_2000, line, 16'b0000_0000_0000_0100);

        $display("[TB] read of 0x1000 with foreign 0x3000 beats interleaved");
        fillRandomBeats();
        applyRead(32'h0000_1000, 2, 1'b1, 1'b0);

        $display("[TB] read and write requested together");
        fillRandomBeats();
        applyRead(32'h0000_4020, 1, 1'b0, 1'b1);

        $display("[TB] reset in the middle of a read");
        fillRandomBeats();
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 256'd0);
        tick();
        bmem_ready = 1'b1;
        tick();
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_1000;
        bmem_rdata  = beatTab[0];
        tick();
        bmem_rdata = beatTab[1];
        tick();
        bmem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_rst");
        applyStimulus(1'b0, 1'b0, 32'd0, 256'd0);
        lastLine = 256'd0;
        tick();
        rst = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_1000;
        bmem_rdata  = beatTab[2];
        tick();
        checkOutput("stale_resp0", dfp_resp, 1'b0);
        bmem_rdata = beatTab[3];
        tick();
        checkOutput("stale_resp1", dfp_resp, 1'b0);
        checkOutput("stale_rdata", dfp_rdata, 256'd0);
        bmem_rvalid = 1'b0;
        fillRandomBeats();
        applyRead(32'h0000_1000, 2, 1'b0, 1'b0);

        $display("[TB] read immediately followed by write");
        fillRandomBeats();
        applyRead(32'h0000_5000, 0, 1'b0, 1'b0);
        applyWrite(32'h0000_6000, randLine(), 16'd0);

        $display("[TB] randomized reads and writes");
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(1, 0));
            if (kind == 0) begin
                fillRandomBeats();
                applyRead($urandom, 3, 1'($urandom_range(1, 0)), 1'b0);
            end else begin
                applyWrite($urandom, randLine(), 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
